// File: rtl/bnn_weight_loader.sv
// bnn_weight_loader: FIFO-staged byte loader that streams BNN weights as nibbles.
// Optional WLOAD_CHECKSUM_EN adds an XOR checksum of every byte sent.
module bnn_weight_loader #(
  parameter int NUM_NEURONS = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       load_en,
  output logic [3:0] weight_nib,
  output logic [3:0] neuron_idx
`ifdef WLOAD_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] LAST = 4'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic [7:0]    head;
  logic [3:0]    idx_nxt;

  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign pop      = (state == S_HI);
  assign head     = mem[rd_ptr];

  assign count_nxt = count
                   + {{AW{1'b0}}, push}
                   - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      neuron_idx <= '0;
    end else begin
      state      <= state_nxt;
      neuron_idx <= idx_nxt;
      count      <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // A start with data already staged skips WAIT so LO follows next cycle.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = neuron_idx;
    busy       = 1'b0;
    done       = 1'b0;
    load_en    = 1'b0;
    weight_nib = 4'h0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          idx_nxt   = 4'h0;
          state_nxt = empty ? S_WAIT : S_LO;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (!empty) begin
          state_nxt = S_LO;
        end
      end
      S_LO: begin
        busy       = 1'b1;
        load_en    = 1'b1;
        weight_nib = head[3:0];
        state_nxt  = S_HI;
      end
      S_HI: begin
        busy       = 1'b1;
        load_en    = 1'b1;
        weight_nib = head[7:4];
        if (neuron_idx == LAST) begin
          state_nxt = S_DONE;
        end else begin
          idx_nxt   = neuron_idx + 4'd1;
          state_nxt = (count_nxt != '0) ? S_LO : S_WAIT;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef WLOAD_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum <= 8'h00;
    end else if (state == S_IDLE && start) begin
      checksum <= 8'h00;
    end else if (pop) begin
      checksum <= checksum ^ head;
    end
  end
`endif

endmodule

// File: tb/tb_bnn_weight_loader.sv
// Directed self-checking bench for bnn_weight_loader (NUM_NEURONS=12, FIFO_DEPTH=4).
// Define WLOAD_CHECKSUM_EN to also exercise the checksum output.
module tb_bnn_weight_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       start;
  logic       busy;
  logic       done;
  logic       load_en;
  logic [3:0] weight_nib;
  logic [3:0] neuron_idx;
`ifdef WLOAD_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int nxt;
  int n;
  logic acc;
  logic hit;

  always #5 clk = ~clk;

  bnn_weight_loader #(
    .NUM_NEURONS(12),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .load_en   (load_en),
    .weight_nib(weight_nib),
    .neuron_idx(neuron_idx)
`ifdef WLOAD_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef WLOAD_CHECKSUM_EN
  logic [7:0] cks_bytes [12] = '{
    8'hFF, 8'h0F, 8'h3C, 8'hC3, 8'hF0, 8'h0F,
    8'h3C, 8'hC3, 8'hF0, 8'h0F, 8'h3C, 8'hC3};
  logic [7:0] cks_exp;
`endif

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    step();
    step();
    check("rst_load_en", load_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nib", weight_nib, 0);
    check("rst_idx", neuron_idx, 0);
    check("rst_wr_ready", wr_ready, 1);
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // fill the FIFO, then hold a fifth byte against back-pressure
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(i);
      step();
    end
    check("full_ready", wr_ready, 0);
    wr_data = 8'h04;
    nxt = 4;
    step();
    step();
    check("held_ready", wr_ready, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (c < 24) begin
        check("s1_load_en", load_en, 1);
        check("s1_busy", busy, 1);
        check("s1_nib", weight_nib, (c % 2 == 0) ? c / 2 : 0);
        check("s1_idx", neuron_idx, c / 2);
        check("s1_done", done, 0);
      end else if (c == 24) begin
        check("s1_done_pulse", done, 1);
        check("s1_done_busy", busy, 0);
        check("s1_done_load_en", load_en, 0);
        check("s1_done_nib", weight_nib, 0);
      end else begin
        check("s1_after_done", done, 0);
        check("s1_after_busy", busy, 0);
        check("s1_after_load_en", load_en, 0);
      end
      if (c == 1) check("s1_full_in_hi", wr_ready, 0);
      if (c == 2) check("s1_ready_after_pop", wr_ready, 1);
      start = (c == 10);
      acc = wr_valid && wr_ready;
      step();
      if (acc) begin
        nxt++;
        if (nxt < 12) wr_data = 8'(nxt);
        else wr_valid = 1'b0;
      end
    end
    check("s1_all_pushed", nxt, 12);
    check("s1_idle_busy", busy, 0);
    check("s1_idle_done", done, 0);

    // start with an empty FIFO: sit in WAIT until a byte shows up
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("s2_wait_busy", busy, 1);
      check("s2_wait_load_en", load_en, 0);
      check("s2_wait_nib", weight_nib, 0);
      step();
    end
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    n = 0;
    while (!load_en && n < 4) begin
      step();
      n++;
    end
    check("s2_lo_seen", load_en, 1);
    check("s2_lo_nib", weight_nib, 4'h5);
    check("s2_lo_idx", neuron_idx, 0);
    step();
    check("s2_hi_load_en", load_en, 1);
    check("s2_hi_nib", weight_nib, 4'hA);
    step();
    check("s2_gap_load_en", load_en, 0);
    check("s2_gap_busy", busy, 1);
    check("s2_gap_idx", neuron_idx, 1);

    // stream to neuron 5, reset during its HI
    nxt = 0;
    wr_data  = 8'h21;
    wr_valid = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (load_en && neuron_idx == 4'd5) begin
        hit = 1'b1;
      end else begin
        acc = wr_valid && wr_ready;
        step();
        if (acc) begin
          nxt++;
          if (nxt < 7) wr_data = 8'h21 + 8'(nxt);
          else wr_valid = 1'b0;
        end
      end
    end
    check("s3_reach_n5", hit, 1);
    check("s3_lo_nib", weight_nib, 4'h5);
    wr_valid = 1'b0;
    step();
    check("s3_hi_load_en", load_en, 1);
    check("s3_hi_nib", weight_nib, 4'h2);
    rst_n = 1'b0;
    step();
    check("s3_rst_load_en", load_en, 0);
    check("s3_rst_busy", busy, 0);
    check("s3_rst_ready", wr_ready, 1);
    check("s3_rst_idx", neuron_idx, 0);
    check("s3_rst_done", done, 0);
    check("s3_rst_nib", weight_nib, 0);
    rst_n = 1'b1;
    step();
    check("s3_post_done", done, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s3_empty_load_en", load_en, 0);
      check("s3_empty_busy", busy, 1);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("s3_final_busy", busy, 0);

`ifdef WLOAD_CHECKSUM_EN
    cks_exp = 8'h00;
    for (int i = 0; i < 12; i++) cks_exp = cks_exp ^ cks_bytes[i];
    nxt = 0;
    wr_data  = cks_bytes[0];
    wr_valid = 1'b1;
    start    = 1'b1;
    hit      = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (done) begin
        hit = 1'b1;
      end else begin
        acc = wr_valid && wr_ready;
        step();
        start = 1'b0;
        if (acc) begin
          nxt++;
          if (nxt < 12) wr_data = cks_bytes[nxt];
          else wr_valid = 1'b0;
        end
      end
    end
    check("cks_done_seen", hit, 1);
    check("cks_value", checksum, cks_exp);
    step();
    step();
    check("cks_hold", checksum, cks_exp);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
